dtw_result_filter: RTL and testbench

Downstream stage of the DTW core: drains the 3-word result records (query id, best-match position, minimum distance) that the core writes into its sink FIFO. It classifies each record against a programmable distance threshold and tags the record with an accept bit. Records are forwarded on an AXI-Stream master, and rejected records can optionally be dropped, so software or the next accelerator stage receives only classified hits.

---
 rtl/dtw_pkg.sv | 29 ++
 rtl/dtw_result_stats.sv | 28 ++
 rtl/dtw_result_filter.sv | 142 ++++++++++++++
 tb/tb_dtw_result_filter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// Shared types and constants for the DTW result path: FSM state encoding,
// record word indices and the accept-bit position in the stream word.
package dtw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_QID,
        ST_RD_POS,
        ST_RD_MIN,
        ST_EVAL,
        ST_TX_QID,
        ST_TX_POS,
        ST_TX_MIN
    } dtw_state_e;

    localparam logic [1:0] WORD_QID  = 2'd0;
    localparam logic [1:0] WORD_POS  = 2'd1;
    localparam logic [1:0] WORD_MIN  = 2'd2;
    localparam int unsigned REC_WORDS = 3;

    localparam int unsigned DTW_AXIS_WIDTH = 32;
    localparam int unsigned ACCEPT_BIT     = DTW_AXIS_WIDTH - 1;

    // Accept bit always sits in the MSB of the stream word.
    function automatic int unsigned accept_bit_pos(input int unsigned axis_w);
        return axis_w - 1;
    endfunction

endpackage

// File: rtl/dtw_result_stats.sv
// Saturating accept/reject counter pair with a synchronous clear that
// overrides any coincident increment.
module dtw_result_stats (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_inc_acc,
    input  logic        i_inc_rej,
    output logic [31:0] o_n_accept,
    output logic [31:0] o_n_reject
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_n_accept <= '0;
            o_n_reject <= '0;
        end else if (i_clr) begin
            o_n_accept <= '0;
            o_n_reject <= '0;
        end else begin
            if (i_inc_acc && (o_n_accept != 32'hFFFF_FFFF))
                o_n_accept <= o_n_accept + 32'd1;
            if (i_inc_rej && (o_n_reject != 32'hFFFF_FFFF))
                o_n_reject <= o_n_reject + 32'd1;
        end
    end

endmodule

// File: rtl/dtw_result_filter.sv
// Drains 3-word DTW result records from a FWFT FIFO, tags each with an accept
// bit against a threshold and forwards (or drops) it on AXI-Stream.
// Optional statistics counters are built when DTW_RESULT_STATS_EN is defined.
module dtw_result_filter
    import dtw_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int AXIS_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      threshold,
    input  logic                  drop_rejected,
    output logic                  busy,
    output logic                  fifo_rden,
    input  logic                  fifo_empty,
    input  logic [AXIS_WIDTH-1:0] fifo_data,
    output logic [AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
`ifdef DTW_RESULT_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [31:0]           n_accept,
    output logic [31:0]           n_reject
`endif
);

    localparam int unsigned ACC_BIT = accept_bit_pos(AXIS_WIDTH);

    dtw_state_e            r_state, w_next;
    logic [AXIS_WIDTH-1:0] r_qid, r_pos;
    logic [WIDTH-1:0]      r_min;
    logic                  r_accept;
    logic                  w_eval_acc;
    logic [1:0]            w_idx;
    logic [AXIS_WIDTH-1:0] w_min_word;

    assign w_eval_acc = (r_min <= threshold);

    // Word slot addressed by the current read or transmit state.
    always_comb begin
        w_idx = WORD_QID;
        case (r_state)
            ST_RD_POS, ST_TX_POS: w_idx = WORD_POS;
            ST_RD_MIN, ST_TX_MIN: w_idx = WORD_MIN;
            default:              w_idx = WORD_QID;
        endcase
    end

    always_comb begin
        w_min_word             = '0;
        w_min_word[WIDTH-1:0]  = r_min;
        w_min_word[ACC_BIT]    = r_accept;
    end

    always_comb begin
        w_next        = r_state;
        fifo_rden     = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        busy          = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy   = 1'b0;
                w_next = ST_RD_QID;
            end
            ST_RD_QID: begin
                busy      = 1'b0;
                fifo_rden = !fifo_empty;
                if (!fifo_empty) w_next = ST_RD_POS;
            end
            ST_RD_POS: begin
                fifo_rden = !fifo_empty;
                if (!fifo_empty) w_next = ST_RD_MIN;
            end
            ST_RD_MIN: begin
                fifo_rden = !fifo_empty;
                if (!fifo_empty) w_next = ST_EVAL;
            end
            ST_EVAL: begin
                w_next = (!w_eval_acc && drop_rejected) ? ST_RD_QID : ST_TX_QID;
            end
            ST_TX_QID: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = r_qid;
                if (m_axis_tready) w_next = ST_TX_POS;
            end
            ST_TX_POS: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = r_pos;
                if (m_axis_tready) w_next = ST_TX_MIN;
            end
            ST_TX_MIN: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tdata  = w_min_word;
                if (m_axis_tready) w_next = ST_RD_QID;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_qid    <= '0;
            r_pos    <= '0;
            r_min    <= '0;
            r_accept <= 1'b0;
        end else begin
            r_state <= w_next;
            if (fifo_rden) begin
                case (w_idx)
                    WORD_QID: r_qid <= fifo_data;
                    WORD_POS: r_pos <= fifo_data;
                    default:  r_min <= fifo_data[WIDTH-1:0];
                endcase
            end
            if (r_state == ST_EVAL) r_accept <= w_eval_acc;
        end
    end

`ifdef DTW_RESULT_STATS_EN
    logic w_inc_acc, w_inc_rej;
    assign w_inc_acc = (r_state == ST_EVAL) &&  w_eval_acc;
    assign w_inc_rej = (r_state == ST_EVAL) && !w_eval_acc;

    dtw_result_stats u_stats (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_clr      (stats_clr),
        .i_inc_acc  (w_inc_acc),
        .i_inc_rej  (w_inc_rej),
        .o_n_accept (n_accept),
        .o_n_reject (n_reject)
    );
`endif

endmodule

// File: tb/tb_dtw_result_filter.sv
// Directed bench for dtw_result_filter: FWFT FIFO model feeding records,
// stream monitor logging beats, hand-computed expected words and latencies.
module tb_dtw_result_filter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] threshold;
    logic        drop_rejected;
    logic        busy, fifo_rden, fifo_empty;
    logic [31:0] fifo_data, m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
`ifdef DTW_RESULT_STATS_EN
    logic        stats_clr;
    logic [31:0] n_accept, n_reject;
`endif

    always #5 clk = ~clk;

    dtw_result_filter #(.WIDTH(16), .AXIS_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .threshold     (threshold),
        .drop_rejected (drop_rejected),
        .busy          (busy),
        .fifo_rden     (fifo_rden),
        .fifo_empty    (fifo_empty),
        .fifo_data     (fifo_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
`ifdef DTW_RESULT_STATS_EN
        ,
        .stats_clr     (stats_clr),
        .n_accept      (n_accept),
        .n_reject      (n_reject)
`endif
    );

    // FWFT FIFO model
    logic [31:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = mem[rd_ptr[5:0]];

    int cyc = 0, npops = 0, nbeats = 0, bad_pops = 0;
    int          pcyc  [0:63];
    int          bcyc  [0:63];
    logic [31:0] bdata [0:63];
    logic        blast [0:63];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rden) begin
            if (fifo_empty) bad_pops <= bad_pops + 1;
            rd_ptr       <= rd_ptr + 1;
            pcyc[npops]  <= cyc;
            npops        <= npops + 1;
        end
        if (m_axis_tvalid && m_axis_tready) begin
            bdata[nbeats] <= m_axis_tdata;
            blast[nbeats] <= m_axis_tlast;
            bcyc[nbeats]  <= cyc;
            nbeats        <= nbeats + 1;
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Output must hold while stalled
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    always @(negedge clk) begin
        if (prev_stall && rst) begin
            chk("hold_valid", {31'd0, m_axis_tvalid}, 32'd1);
            chk("hold_data", m_axis_tdata, prev_data);
        end
        prev_stall <= m_axis_tvalid && !m_axis_tready && rst;
        prev_data  <= m_axis_tdata;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr++;
    endtask

    task automatic send_rec(input logic [31:0] q, input logic [31:0] p, input logic [31:0] m);
        push(q); push(p); push(m);
    endtask

    task automatic wait_beats(input int target, input int budget);
        int k = 0;
        while (nbeats < target && k < budget) begin
            tick(1);
            k++;
        end
        chk("beat_timeout", nbeats, target);
    endtask

    task automatic chk_rec(input string tag, input int b, input logic [31:0] q,
                           input logic [31:0] p, input logic [31:0] m);
        chk({tag, "_w0"}, bdata[b], q);
        chk({tag, "_w1"}, bdata[b+1], p);
        chk({tag, "_w2"}, bdata[b+2], m);
        chk({tag, "_last"}, {29'd0, blast[b], blast[b+1], blast[b+2]}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0, p0, k;
        logic [3:0] pat;
        threshold     = 16'd100;
        drop_rejected = 1'b0;
        m_axis_tready = 1'b1;
`ifdef DTW_RESULT_STATS_EN
        stats_clr     = 1'b0;
`endif
        tick(3);
        chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_tlast",  {31'd0, m_axis_tlast},  32'd0);
        chk("rst_tdata",  m_axis_tdata,           32'd0);
        chk("rst_busy",   {31'd0, busy},          32'd0);
        chk("rst_rden",   {31'd0, fifo_rden},     32'd0);
        rst = 1'b1;
        tick(3);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Basic accept, latency and busy
        b0 = nbeats; p0 = npops;
        send_rec(32'd7, 32'd1234, 32'd50);
        tick(2);
        chk("t1_busy_rd", {31'd0, busy}, 32'd1);
        wait_beats(b0 + 3, 40);
        chk_rec("t1", b0, 32'd7, 32'd1234, 32'h8000_0032);
        chk("t1_first_lat", bcyc[b0] - pcyc[p0], 32'd4);
        chk("t1_last_lat",  bcyc[b0+2] - pcyc[p0], 32'd6);
        chk("t1_busy_done", {31'd0, busy}, 32'd0);

        // Equality accepts
        b0 = nbeats;
        send_rec(32'd8, 32'd99, 32'd100);
        wait_beats(b0 + 3, 40);
        chk_rec("t2", b0, 32'd8, 32'd99, 32'h8000_0064);

        // Dropped reject followed immediately by an accepted record
        drop_rejected = 1'b1;
        b0 = nbeats; p0 = npops;
        send_rec(32'd9, 32'd5, 32'd300);
        send_rec(32'd11, 32'd6, 32'd20);
        wait_beats(b0 + 3, 60);
        chk_rec("t3", b0, 32'd11, 32'd6, 32'h8000_0014);
        chk("t3_drop_turn", pcyc[p0+3] - pcyc[p0], 32'd4);
        chk("t3_pops", npops - p0, 32'd6);
        drop_rejected = 1'b0;

        // Forwarded reject
        b0 = nbeats;
        send_rec(32'd9, 32'd5, 32'd300);
        wait_beats(b0 + 3, 40);
        chk_rec("t4", b0, 32'd9, 32'd5, 32'h0000_012C);

        // FIFO gaps and tready 1,0,0,1; upper min bits ignored
        b0 = nbeats; p0 = npops;
        pat = 4'b1001;
        for (int i = 0; i < 80; i++) begin
            if (i == 0) push(32'h21);
            if (i == 3) push(32'h22);
            if (i == 6) push(32'h0001_0033);
            m_axis_tready = pat[i % 4];
            tick(1);
            if (nbeats >= b0 + 3) break;
        end
        m_axis_tready = 1'b1;
        chk("t5_beats", nbeats, b0 + 3);
        chk_rec("t5", b0, 32'h21, 32'h22, 32'h8000_0033);
        chk("t5_pops", npops - p0, 32'd3);
`ifdef DTW_RESULT_STATS_EN
        chk("st_acc4", n_accept, 32'd4);
        chk("st_rej2", n_reject, 32'd2);
`endif

        // Reset while in TX_POS
        m_axis_tready = 1'b0;
        send_rec(32'h31, 32'h32, 32'h10);
        k = 0;
        while (!m_axis_tvalid && k < 20) begin
            tick(1);
            k++;
        end
        chk("t6_reach_tx", {31'd0, m_axis_tvalid}, 32'd1);
        m_axis_tready = 1'b1;
        tick(1);
        m_axis_tready = 1'b0;
        tick(1);
        chk("t6_txpos_data", m_axis_tdata, 32'h32);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("t6_rst_tdata",  m_axis_tdata, 32'd0);
        chk("t6_rst_busy",   {31'd0, busy}, 32'd0);
        tick(2);
        rst = 1'b1;
        tick(2);
        m_axis_tready = 1'b1;
        b0 = nbeats;
        send_rec(32'h41, 32'h42, 32'h05);
        wait_beats(b0 + 3, 40);
        chk_rec("t6", b0, 32'h41, 32'h42, 32'h8000_0005);
`ifdef DTW_RESULT_STATS_EN
        chk("st_acc_after_rst", n_accept, 32'd1);
        chk("st_rej_after_rst", n_reject, 32'd0);
        // Clear coinciding with an accept in EVAL
        p0 = npops; b0 = nbeats;
        send_rec(32'h51, 32'h52, 32'h07);
        k = 0;
        while (npops < p0 + 3 && k < 20) begin
            tick(1);
            k++;
        end
        stats_clr = 1'b1;
        tick(1);
        stats_clr = 1'b0;
        wait_beats(b0 + 3, 40);
        chk("st_clr_acc", n_accept, 32'd0);
        chk("st_clr_rej", n_reject, 32'd0);
`endif

        chk("no_empty_pops", bad_pops, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
